// File: rtl/joy_db9_pkg.sv
// Shared definitions for the DB9 joystick conditioning stage: word layout,
// button bit positions and the Mode+Start combo state encoding.
package joy_db9_pkg;

    localparam int JOY_W     = 12;
    localparam int DEB_CNT_W = 4;

    localparam int JOY_R = 0;
    localparam int JOY_L = 1;
    localparam int JOY_D = 2;
    localparam int JOY_U = 3;
    localparam int JOY_A = 4;
    localparam int JOY_B = 5;
    localparam int JOY_C = 6;
    localparam int JOY_X = 7;
    localparam int JOY_Y = 8;
    localparam int JOY_Z = 9;
    localparam int JOY_S = 10;
    localparam int JOY_M = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FIRED = 2'd2
    } combo_state_t;

endpackage

// File: rtl/joy_db9_debounce_bit.sv
// One button bit: two-flop synchroniser followed by a tick-counted debouncer.
// The output only flips after DEB_TICKS consecutive disagreeing ticks.
module joy_db9_debounce_bit
    import joy_db9_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic tick,
    output logic dout
);

    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 out_reg;
    logic [DEB_CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            out_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            // Any agreement restarts the count, so short glitches never accumulate.
            if (sync2_reg == out_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == DEB_CNT_W'(DEB_TICKS - 1)) begin
                    out_reg <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + DEB_CNT_W'(1);
                end
            end
        end
    end

    assign dout = out_reg;

endmodule

// File: rtl/joy_db9_cond.sv
// Conditions both DB9 joystick words: per-bit sync + debounce, per-port change
// strobes and a held Mode+Start detector that requests the OSD.
module joy_db9_cond
    import joy_db9_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int DEB_TICKS   = 4,
    parameter int COMBO_TICKS = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [JOY_W-1:0] joy1_in,
    input  logic [JOY_W-1:0] joy2_in,
    output logic [JOY_W-1:0] joy1_out,
    output logic [JOY_W-1:0] joy2_out,
    output logic             joy1_chg,
    output logic             joy2_chg,
    output logic             osd_req,
    output logic             osd_hold
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(COMBO_TICKS + 1);

    logic [PRE_W-1:0] presc_reg;
    logic             tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (presc_reg == PRE_W'(TICK_DIV - 1)) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRE_W'(1);
        end
    end

    assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

    // Port 1 occupies the low half, port 2 the high half.
    logic [2*JOY_W-1:0] raw_all;
    logic [2*JOY_W-1:0] deb_all;

    assign raw_all = {joy2_in, joy1_in};

    generate
        for (genvar gi = 0; gi < 2 * JOY_W; gi++) begin : g_bit
            joy_db9_debounce_bit #(
                .DEB_TICKS(DEB_TICKS)
            ) u_bit (
                .clk  (clk),
                .reset(reset),
                .din  (raw_all[gi]),
                .tick (tick),
                .dout (deb_all[gi])
            );
        end
    endgenerate

    assign joy1_out = deb_all[JOY_W-1:0];
    assign joy2_out = deb_all[2*JOY_W-1:JOY_W];

    logic [JOY_W-1:0] joy1_prev_reg;
    logic [JOY_W-1:0] joy2_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            joy1_prev_reg <= '0;
            joy2_prev_reg <= '0;
        end else begin
            joy1_prev_reg <= joy1_out;
            joy2_prev_reg <= joy2_out;
        end
    end

    assign joy1_chg = |(joy1_out ^ joy1_prev_reg);
    assign joy2_chg = |(joy2_out ^ joy2_prev_reg);

    logic combo;
    assign combo = (joy1_out[JOY_M] & joy1_out[JOY_S]) |
                   (joy2_out[JOY_M] & joy2_out[JOY_S]);

    combo_state_t      state_reg;
    combo_state_t      state_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;
    logic              fire;
    logic              osd_req_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            osd_req_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            osd_req_reg <= fire;
        end
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        fire       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (combo) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end
            end
            HOLD: begin
                // Release wins over a coincident tick.
                if (!combo) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (hold_reg == HOLD_W'(COMBO_TICKS - 1)) begin
                        fire       = 1'b1;
                        state_next = FIRED;
                    end else begin
                        hold_next = hold_reg + HOLD_W'(1);
                    end
                end
            end
            FIRED: begin
                if (!combo) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        osd_hold = (state_reg == FIRED);
        osd_req  = osd_req_reg;
    end

endmodule

// File: tb/tb_joy_db9_cond.sv
// Directed scenarios plus random button traffic for joy_db9_cond, checked every
// cycle against a word-level behavioural model of the conditioning rules.
module tb_joy_db9_cond;

    localparam int TD = 4;
    localparam int DT = 3;
    localparam int CT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] joy1_in = '0;
    logic [11:0] joy2_in = '0;
    logic [11:0] joy1_out;
    logic [11:0] joy2_out;
    logic        joy1_chg;
    logic        joy2_chg;
    logic        osd_req;
    logic        osd_hold;

    always #5 clk = ~clk;

    joy_db9_cond #(
        .TICK_DIV   (TD),
        .DEB_TICKS  (DT),
        .COMBO_TICKS(CT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .joy1_in (joy1_in),
        .joy2_in (joy2_in),
        .joy1_out(joy1_out),
        .joy2_out(joy2_out),
        .joy1_chg(joy1_chg),
        .joy2_chg(joy2_chg),
        .osd_req (osd_req),
        .osd_hold(osd_hold)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: words delayed by two samples, per-bit run length of
    // disagreeing ticks, and the number of ticks the combo has been held.
    logic [11:0] m_s1[2];
    logic [11:0] m_s2[2];
    logic [11:0] m_out[2];
    int          m_run[2][12];
    int          m_presc;
    int          m_tks;
    logic        m_chg[2];
    logic        m_req;

    int cyc = 0;
    int c_chg1, c_chg2, c_req;
    int last_chg1, last_chg2, first_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_s1[p]  = '0;
            m_s2[p]  = '0;
            m_out[p] = '0;
            m_chg[p] = 1'b0;
            for (int b = 0; b < 12; b++) m_run[p][b] = 0;
        end
        m_presc = 0;
        m_tks   = -1;
        m_req   = 1'b0;
    endtask

    task automatic model_step();
        logic        tick;
        logic        combo;
        logic [11:0] nxt;
        if (reset) begin
            model_reset();
            return;
        end
        tick    = (m_presc == TD - 1);
        m_presc = (m_presc + 1) % TD;
        combo   = (m_out[0][11] & m_out[0][10]) | (m_out[1][11] & m_out[1][10]);
        m_req   = 1'b0;
        if (!combo)                     m_tks = -1;
        else if (m_tks < 0)             m_tks = 0;
        else if (tick && m_tks < CT) begin
            m_tks++;
            if (m_tks == CT) m_req = 1'b1;
        end
        for (int p = 0; p < 2; p++) begin
            nxt = m_out[p];
            for (int b = 0; b < 12; b++) begin
                if (m_s2[p][b] == m_out[p][b]) begin
                    m_run[p][b] = 0;
                end else if (tick) begin
                    m_run[p][b]++;
                    if (m_run[p][b] == DT) begin
                        nxt[b]      = m_s2[p][b];
                        m_run[p][b] = 0;
                    end
                end
            end
            m_chg[p] = (nxt != m_out[p]);
            m_out[p] = nxt;
        end
        m_s2[0] = m_s1[0];
        m_s2[1] = m_s1[1];
        m_s1[0] = joy1_in;
        m_s1[1] = joy2_in;
    endtask

    task automatic check_outputs();
        check("joy1_out", 32'(joy1_out), 32'(m_out[0]));
        check("joy2_out", 32'(joy2_out), 32'(m_out[1]));
        check("joy1_chg", 32'(joy1_chg), 32'(m_chg[0]));
        check("joy2_chg", 32'(joy2_chg), 32'(m_chg[1]));
        check("osd_req",  32'(osd_req),  32'(m_req));
        check("osd_hold", 32'(osd_hold), 32'(m_tks == CT));
    endtask

    task automatic clr_cnt();
        c_chg1 = 0; c_chg2 = 0; c_req = 0;
        last_chg1 = -1; last_chg2 = -1; first_req = -1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (joy1_chg === 1'b1) begin c_chg1++; last_chg1 = cyc; end
        if (joy2_chg === 1'b1) begin c_chg2++; last_chg2 = cyc; end
        if (osd_req === 1'b1) begin
            if (c_req == 0) first_req = cyc;
            c_req++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_out1(input logic [11:0] v, input int budget, output int took);
        took = 0;
        while (joy1_out !== v && took < budget) begin
            cycle();
            took++;
        end
    endtask

    int took;
    int t0;

    initial begin
        model_reset();
        clr_cnt();

        // Reset state
        run(3);
        $display("[TB] reset: joy1_out=%h joy2_out=%h osd_req=%b osd_hold=%b", joy1_out, joy2_out, osd_req, osd_hold);
        reset = 1'b0;

        // 1: single button on port 1
        clr_cnt();
        joy1_in = 12'h010;
        wait_out1(12'h010, 40, took);
        check("t1_latency_in_9_14", 32'(took >= 9 && took <= 14), 32'd1);
        run(20);
        check("t1_chg1_count", 32'(c_chg1), 32'd1);
        check("t1_chg2_count", 32'(c_chg2), 32'd0);
        check("t1_joy2_out", 32'(joy2_out), 32'h0);
        $display("[TB] t1: latency=%0d chg1=%0d chg2=%0d", took, c_chg1, c_chg2);

        // 2: glitch of 2 tick periods is filtered, 3 tick periods passes
        clr_cnt();
        joy2_in = 12'h008; run(2 * TD);
        joy2_in = 12'h000; run(30);
        check("t2_short_out", 32'(joy2_out), 32'h0);
        check("t2_short_chg", 32'(c_chg2), 32'd0);
        joy2_in = 12'h008; run(3 * TD);
        joy2_in = 12'h000; run(40);
        check("t2_long_chg", 32'(c_chg2), 32'd2);
        check("t2_long_out", 32'(joy2_out), 32'h0);
        $display("[TB] t2: chg2=%0d joy2_out=%h", c_chg2, joy2_out);

        // 3: both ports change on the same clock
        joy1_in = 12'h000; run(30);
        clr_cnt();
        joy1_in = 12'h00F; joy2_in = 12'h0F0;
        run(30);
        check("t3_chg1_count", 32'(c_chg1), 32'd1);
        check("t3_chg2_count", 32'(c_chg2), 32'd1);
        check("t3_same_cycle", 32'(last_chg1), 32'(last_chg2));
        check("t3_joy1_out", 32'(joy1_out), 32'h00F);
        check("t3_joy2_out", 32'(joy2_out), 32'h0F0);
        $display("[TB] t3: chg1@%0d chg2@%0d", last_chg1, last_chg2);

        // 4: full combo hold
        joy1_in = 12'h000; joy2_in = 12'h000; run(30);
        clr_cnt();
        joy1_in = 12'hC00;
        wait_out1(12'hC00, 40, took);
        t0 = cyc;
        run(60);
        check("t4_req_count", 32'(c_req), 32'd1);
        check("t4_req_delay", 32'(first_req - t0), 32'(CT * TD));
        check("t4_hold_high", 32'(osd_hold), 32'd1);
        joy1_in = 12'h000; run(30);
        check("t4_hold_low", 32'(osd_hold), 32'd0);
        check("t4_req_once", 32'(c_req), 32'd1);
        $display("[TB] t4: req_delay=%0d req_count=%0d", first_req - t0, c_req);

        // 5: combo released early, then a full hold
        clr_cnt();
        joy1_in = 12'hC00;
        wait_out1(12'hC00, 40, took);
        joy1_in = 12'h000; run(40);
        check("t5_abort_req", 32'(c_req), 32'd0);
        check("t5_abort_hold", 32'(osd_hold), 32'd0);
        joy1_in = 12'hC00; run(50);
        check("t5_refire_req", 32'(c_req), 32'd1);
        joy1_in = 12'h000; run(30);
        $display("[TB] t5: req_count=%0d", c_req);

        // 6: async reset in the middle of a hold
        clr_cnt();
        joy1_in = 12'hC00;
        wait_out1(12'hC00, 40, took);
        run(9);
        #1 reset = 1'b1;
        model_reset();
        #1 check_outputs();
        check("t6_rst_out", 32'(joy1_out), 32'h0);
        run(3);
        reset = 1'b0;
        clr_cnt();
        took = 0;
        do begin
            cycle();
            took++;
        end while (osd_req !== 1'b1 && took < 60);
        check("t6_req_after_reset", 32'(took), 32'd32);
        check("t6_chg1_count", 32'(c_chg1), 32'd1);
        joy1_in = 12'h000; run(30);
        $display("[TB] t6: req after %0d cycles", took);

        // Random traffic, including occasional Mode+Start
        for (int s = 0; s < 30; s++) begin
            joy1_in = 12'($urandom);
            joy2_in = 12'($urandom);
            if ($urandom_range(0, 3) == 0) joy1_in[11:10] = 2'b11;
            run($urandom_range(2, 40));
            $display("[TB] rand %0d: joy1_in=%h joy2_in=%h joy1_out=%h joy2_out=%h", s, joy1_in, joy2_in, joy1_out, joy2_out);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/joy_db9_cond.md
Name: joy_db9_cond

Overview:
- Downstream conditioning stage for the DB9 Mega Drive splitter decoder.
- Consumes the two 12-bit active-high joystick words (bit order MSZYXCBAUDLR: 11=Mode, 10=Start, 9=Z, 8=Y, 7=X, 6=C, 5=B, 4=A, 3=Up, 2=Down, 1=Left, 0=Right).
- Synchronises them into the core clock domain and debounces every bit.
- Produces per-port change strobes and detects a held Mode+Start combo as an OSD request, for the core's input mux.

Parameters:
TICK_DIV, 50000, core clocks per debounce/combo tick (1 ms at 50 MHz); legal range >= 2
DEB_TICKS, 4, consecutive ticks a bit must disagree with its output before the output flips; legal range 1..15
COMBO_TICKS, 1000, ticks Mode+Start must be held before osd_req fires; legal range >= 1

Ports:
clk  in  1  core clock, all logic on rising edge
reset  in  1  asynchronous, active-high
joy1_in  in  12  port 1 buttons, active-high, asynchronous to clk
joy2_in  in  12  port 2 buttons, active-high, asynchronous to clk
joy1_out  out  12  debounced port 1
joy2_out  out  12  debounced port 2
joy1_chg  out  1  one-cycle pulse when joy1_out changes
joy2_chg  out  1  one-cycle pulse when joy2_out changes
osd_req  out  1  one-cycle pulse on combo completion
osd_hold  out  1  level, high while the combo FSM is in FIRED

Behaviour:
- Reset: async, active-high. All sync flops, joyN_out, chg, osd_req, osd_hold, prescaler, debounce counters and hold counter go to 0. FSM goes to IDLE. Nothing fires on the first edge after reset release.
- Sync: 2-flop synchroniser per input bit, 24 bits total. No word-level coherence is required.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 for one clk when the count equals TICK_DIV-1.
- Per-bit debounce:
  - Counter cnt, width 4.
  - If synced bit == out bit: cnt <= 0.
  - Else on tick:
    - If cnt == DEB_TICKS-1: out <= synced bit, cnt <= 0.
    - Otherwise cnt++.
  - Else, no tick: hold.
  - A glitch shorter than DEB_TICKS ticks never reaches the output. Any agreement clears cnt.
  - Latency from input edge to output: 2 clk (sync) + between DEB_TICKS-1 and DEB_TICKS tick periods.
- Change strobe:
  - joyN_chg = 1 for exactly the clk cycle in which joyN_out first shows a new value, whatever the number of bits that flipped.
  - Both ports may strobe in the same cycle.
- Combo FSM. combo = (joy1_out[11] & joy1_out[10]) | (joy2_out[11] & joy2_out[10]).
  - IDLE: combo -> HOLD, hold counter <= 0.
  - HOLD:
    - !combo -> IDLE; this takes priority over a simultaneous tick.
    - Else on tick with hold == COMBO_TICKS-1: osd_req pulse for 1 clk, go to FIRED.
    - Else on tick: hold++.
  - FIRED: osd_hold = 1. !combo -> IDLE.
  - osd_req cannot repeat until the combo is released and then pressed again.
  - Hold counter width is $clog2(COMBO_TICKS+1).
- joyN_out is never masked by the combo logic.
- Reset mid-operation: everything returns to reset values immediately. A partially held combo does not fire.

Decomposition:
- Package joy_db9_pkg:
  - JOY_W = 12.
  - Bit index constants JOY_R=0, JOY_L=1, JOY_D=2, JOY_U=3, JOY_A=4, JOY_B=5, JOY_C=6, JOY_X=7, JOY_Y=8, JOY_Z=9, JOY_S=10, JOY_M=11.
  - Combo FSM enum {IDLE, HOLD, FIRED}.
- Sub-module joy_db9_debounce_bit: one bit with its sync, counter and output flop, taking tick as an input.
  - Instantiated 24 times via generate.
  - The prescaler, chg logic and FSM stay in the top.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3, COMBO_TICKS=5.
1. Reset, then joy1_in=0x010 held steady:
   - joy1_out becomes 0x010 on the tick that completes 3 disagreeing ticks (9..14 clk after the edge).
   - joy1_chg pulses exactly once.
   - joy2_out and joy2_chg stay 0.
2. Glitch: joy2_in[3] high for 2 tick periods, then low -> joy2_out stays 0x000 and joy2_chg never pulses. Repeat with 3 tick periods -> the bit sets, later clears, and chg pulses twice in total.
3. Simultaneous: joy1_in=0x00F and joy2_in=0x0F0 applied on the same clk -> both outputs update on the same cycle, both chg pulse on the same cycle, one pulse each.
4. Combo: joy1_in=0xC00 held:
   - osd_req pulses once, 5 ticks after joy1_out reaches 0xC00.
   - osd_hold = 1 until the input is released and debounced, then 0.
   - Continued holding produces no second pulse.
5. Combo aborted: 0xC00 held for 3 ticks after debounce, then 0x000 -> no osd_req; FSM returns to IDLE, and a new full hold fires normally.
6. Async reset asserted mid-HOLD with joy1_out=0xC00 -> all outputs 0 immediately. After release with the input still 0xC00, osd_req fires only after the debounce period plus 5 fresh ticks.
